// File: rtl/ahb_pkg.sv
// Shared AHB encodings, fixed-burst beat-count constants and arbiter FSM states.
// Imported by the round-robin arbiter and its picker.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Remaining SEQ beats after the NONSEQ beat of a fixed-length burst.
  localparam logic [3:0] BEATS4_LOAD  = 4'd3;
  localparam logic [3:0] BEATS8_LOAD  = 4'd7;
  localparam logic [3:0] BEATS16_LOAD = 4'd15;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } arb_state_e;

  // Zero means "not a fixed-length burst" (SINGLE / INCR).
  function automatic logic [3:0] burst_load(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   burst_load = BEATS4_LOAD;
      2'b10:   burst_load = BEATS8_LOAD;
      2'b11:   burst_load = BEATS16_LOAD;
      default: burst_load = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer,
// searching pointer+1 .. pointer+3 and finally the pointer itself.
module ahb_rr_pick
  import ahb_pkg::*;
(
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [1:0] winner,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    winner = pointer;
    found  = 1'b0;
    idx    = pointer;
    any    = |request;
    for (int k = 1; k <= 4; k++) begin
      idx = pointer + k[1:0];
      if (!found && request[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Four-master AHB round-robin arbiter with fixed-burst hold and locked-transfer hold.
// State is exposed on dbg_state/dbg_count for checkers.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       SYSRST,
  input  logic [3:0] HBUSREQ,
  input  logic [3:0] HLOCK,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  output logic [3:0] HGRANT,
  output logic [1:0] HMASTER,
  output logic [1:0] HMASTER_D,
  output logic       HMASTLOCK,
  output arb_state_e dbg_state,
  output logic [3:0] dbg_count
);

  localparam logic [1:0] DEF_MASTER = 2'(DEFAULT_MASTER);

  arb_state_e state, state_n;
  logic [3:0] count, count_n;
  logic [1:0] master_n;
  logic       lock_n;
  logic [1:0] pick_winner;
  logic       pick_any;
  logic [1:0] rearb_master;
  logic [3:0] load;

  ahb_rr_pick u_pick (
    .request (HBUSREQ),
    .pointer (HMASTER),
    .winner  (pick_winner),
    .any     (pick_any)
  );

  assign rearb_master = pick_any ? pick_winner : DEF_MASTER;
  assign load         = burst_load(HBURST);
  assign dbg_state    = state;
  assign dbg_count    = count;

  // HREADY is the only advance qualifier: nothing moves on a wait-stated edge.
  always_comb begin
    state_n  = state;
    count_n  = count;
    master_n = HMASTER;
    lock_n   = HMASTLOCK;
    if (HREADY) begin
      unique case (state)
        ST_ARB: begin
          if (HLOCK[HMASTER]) begin
            state_n = ST_LOCK;
            lock_n  = 1'b1;
          end else if (HTRANS == HTRANS_NONSEQ && load != 4'd0) begin
            state_n = ST_BURST;
            count_n = load;
          end else begin
            master_n = rearb_master;
          end
        end
        ST_BURST: begin
          if (HLOCK[HMASTER]) begin
            state_n = ST_LOCK;
            lock_n  = 1'b1;
            count_n = 4'd0;
          end else if (HTRANS == HTRANS_SEQ) begin
            if (count == 4'd1) begin
              state_n  = ST_ARB;
              count_n  = 4'd0;
              master_n = rearb_master;
            end else begin
              count_n = count - 4'd1;
            end
          end else if (HTRANS != HTRANS_BUSY) begin
            // Early termination; a fresh NONSEQ by the same owner starts a new burst.
            master_n = rearb_master;
            state_n  = ST_ARB;
            count_n  = 4'd0;
            if (HTRANS == HTRANS_NONSEQ && rearb_master == HMASTER && load != 4'd0) begin
              state_n = ST_BURST;
              count_n = load;
            end
          end
        end
        ST_LOCK: begin
          if (!HLOCK[HMASTER]) begin
            state_n  = ST_ARB;
            lock_n   = 1'b0;
            master_n = rearb_master;
          end
        end
        default: state_n = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state     <= ST_ARB;
      count     <= 4'd0;
      HMASTER   <= DEF_MASTER;
      HMASTER_D <= DEF_MASTER;
      HGRANT    <= 4'b0001 << DEF_MASTER;
      HMASTLOCK <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      HMASTER   <= master_n;
      HGRANT    <= 4'b0001 << master_n;
      HMASTLOCK <= lock_n;
      if (HREADY) HMASTER_D <= HMASTER;
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: reset, rotation, bursts, locking,
// early termination and asynchronous reset mid-burst.
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  logic       HCLK = 1'b0;
  logic       SYSRST;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic       HREADY;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;
  arb_state_e dbg_state;
  logic [3:0] dbg_count;

  int checks = 0;
  int errors = 0;

  ahb_rr_arbiter #(.DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .SYSRST    (SYSRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] m);
    check({tag, "_hgrant"}, 32'(HGRANT), 32'(g));
    check({tag, "_hmaster"}, 32'(HMASTER), 32'(m));
  endtask

  initial begin
    SYSRST = 1'b1; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HREADY = 1'b1;
    HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    tick(); tick();
    check_grant("rst", 4'b0001, 2'd0);
    check("rst_hmaster_d", 32'(HMASTER_D), 32'd0);
    check("rst_mastlock", 32'(HMASTLOCK), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_ARB));
    check("rst_count", 32'(dbg_count), 32'd0);
    SYSRST = 1'b0;

    // No requesters: default master keeps the grant
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("idle_default", 4'b0001, 2'd0);
    end

    // All request, SINGLE transfers: rotate 1,2,3,0,1
    HBUSREQ = 4'b1111; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_SINGLE;
    tick(); check_grant("rr1", 4'b0010, 2'd1); check("rr1_d", 32'(HMASTER_D), 32'd0);
    tick(); check_grant("rr2", 4'b0100, 2'd2); check("rr2_d", 32'(HMASTER_D), 32'd1);
    tick(); check_grant("rr3", 4'b1000, 2'd3);
    tick(); check_grant("rr4", 4'b0001, 2'd0);
    tick(); check_grant("rr5", 4'b0010, 2'd1);

    // Wait state holds everything
    HREADY = 1'b0;
    tick(); check_grant("wait_hold", 4'b0010, 2'd1); check("wait_hold_d", 32'(HMASTER_D), 32'd0);
    HREADY = 1'b1;

    // Master 2 INCR8 with a BUSY beat inside
    tick(); check_grant("to_m2", 4'b0100, 2'd2);
    HBURST = HBURST_INCR8;
    tick(); check_grant("incr8_b1", 4'b0100, 2'd2);
    check("incr8_state", 32'(dbg_state), 32'(ST_BURST));
    check("incr8_load", 32'(dbg_count), 32'd7);
    HTRANS = HTRANS_SEQ;
    for (int b = 2; b <= 4; b++) begin
      tick(); check_grant("incr8_seq", 4'b0100, 2'd2);
    end
    check("incr8_cnt4", 32'(dbg_count), 32'd4);
    HTRANS = HTRANS_BUSY;
    tick(); check("incr8_busy_cnt", 32'(dbg_count), 32'd4); check_grant("incr8_busy", 4'b0100, 2'd2);
    HTRANS = HTRANS_SEQ;
    for (int b = 5; b <= 7; b++) begin
      tick(); check_grant("incr8_seq", 4'b0100, 2'd2);
    end
    check("incr8_cnt1", 32'(dbg_count), 32'd1);
    tick(); check_grant("incr8_end", 4'b1000, 2'd3);
    check("incr8_end_state", 32'(dbg_state), 32'(ST_ARB));

    // Master 1 lock with HREADY toggling
    HBUSREQ = 4'b0010; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    tick(); check_grant("to_m1", 4'b0010, 2'd1);
    HLOCK = 4'b0010; HBUSREQ = 4'b1111; HTRANS = HTRANS_NONSEQ;
    tick(); check("lock_state", 32'(dbg_state), 32'(ST_LOCK)); check("lock_ml", 32'(HMASTLOCK), 32'd1);
    for (int c = 0; c < 5; c++) begin
      HREADY = (c % 2 == 0) ? 1'b0 : 1'b1;
      tick(); check_grant("lock_hold", 4'b0010, 2'd1); check("lock_hold_ml", 32'(HMASTLOCK), 32'd1);
    end
    HLOCK = 4'b0000; HREADY = 1'b0;
    tick(); check_grant("unlock_wait", 4'b0010, 2'd1); check("unlock_wait_ml", 32'(HMASTLOCK), 32'd1);
    HREADY = 1'b1;
    tick(); check_grant("unlock", 4'b0100, 2'd2); check("unlock_ml", 32'(HMASTLOCK), 32'd0);
    check("unlock_d", 32'(HMASTER_D), 32'd1);

    // Master 2 INCR16 terminated by IDLE after beat 3
    HBURST = HBURST_INCR16; HTRANS = HTRANS_NONSEQ;
    tick(); check("incr16_load", 32'(dbg_count), 32'd15);
    HTRANS = HTRANS_SEQ;
    tick(); tick(); check("incr16_cnt", 32'(dbg_count), 32'd13); check_grant("incr16_hold", 4'b0100, 2'd2);
    HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    tick(); check_grant("incr16_term", 4'b1000, 2'd3);
    check("incr16_term_state", 32'(dbg_state), 32'(ST_ARB)); check("incr16_term_d", 32'(HMASTER_D), 32'd2);
    tick(); check_grant("post_term", 4'b0001, 2'd0); check("post_term_d", 32'(HMASTER_D), 32'd3);

    // Early NONSEQ by the same sole requester restarts a burst
    HBUSREQ = 4'b0001; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR4;
    tick(); check("incr4_load", 32'(dbg_count), 32'd3);
    HTRANS = HTRANS_SEQ;
    tick(); check("incr4_cnt", 32'(dbg_count), 32'd2);
    HTRANS = HTRANS_NONSEQ;
    tick(); check("restart_state", 32'(dbg_state), 32'(ST_BURST)); check("restart_load", 32'(dbg_count), 32'd3);
    check_grant("restart", 4'b0001, 2'd0);
    HBURST = HBURST_SINGLE;
    tick(); check("single_state", 32'(dbg_state), 32'(ST_ARB)); check("single_cnt", 32'(dbg_count), 32'd0);

    // Owner drops its request in ARB
    HBUSREQ = 4'b0100; HTRANS = HTRANS_IDLE;
    tick(); check_grant("drop_req", 4'b0100, 2'd2);

    // Reset asserted during beat 4 of master 3 INCR8
    HBUSREQ = 4'b1000;
    tick(); check_grant("to_m3", 4'b1000, 2'd3);
    HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR8;
    tick();
    HTRANS = HTRANS_SEQ;
    tick(); tick(); check("m3_cnt", 32'(dbg_count), 32'd5);
    HREADY = 1'b0;
    #2 SYSRST = 1'b1;
    #1;
    check_grant("async_rst", 4'b0001, 2'd0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_ARB));
    check("async_rst_cnt", 32'(dbg_count), 32'd0);
    check("async_rst_d", 32'(HMASTER_D), 32'd0);
    tick();
    SYSRST = 1'b0; HREADY = 1'b1; HBUSREQ = 4'b0000; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    tick(); check_grant("post_rst", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
